// File: rtl/prog_rom_server.sv
// prog_rom_server: 16-bit instruction ROM for the ALU core, loadable from a byte-stream loader.
// Latency: q_rom follows the address sampled one rising edge earlier. The loader takes one byte per cycle.
// Backpressure: load_ready is low only during CLEAR. Reads return NOP_WORD while CLEAR or LOAD is active.
// Build option: define PROG_ROM_CLEAR_EN so that reset fills the array with NOP_WORD (CLEAR state).
// Without it, reset goes straight to IDLE and the array contents stay undefined.
module prog_rom_server #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [15:0] NOP_WORD   = 16'h0018
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address_rom,
  output logic [15:0] q_rom,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_busy,
  output logic [15:0] load_count,
  output logic        load_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] WP_ONE = 1;
  localparam logic [15:0] CNT_ONE = 16'd1;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_LOAD} state_t;

  state_t              state;
  logic [DEPTH_LOG2:0] wp;          // one extra bit so "full" (wp == DEPTH) can be represented
  logic                phase_high;  // next byte of the load is the high byte of a word
  logic [7:0]          low_byte;
  logic [15:0]         mem [DEPTH];

  logic                   accept;
  logic                   wp_full;
  logic                   wr_en;
  logic [DEPTH_LOG2-1:0]  wr_addr;
  logic [15:0]            wr_data;

  assign accept  = load_valid & load_ready;
  assign wp_full = wp[DEPTH_LOG2];

  // Select the array write: a fill word during CLEAR, or an assembled word on a high-byte handshake
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wp[DEPTH_LOG2-1:0];
    wr_data = NOP_WORD;
    if (state == ST_CLEAR) begin
      wr_en = 1'b1;
    end else if (state == ST_LOAD && accept && phase_high && !wp_full) begin
      wr_en   = 1'b1;
      wr_data = {load_data, low_byte};
    end
  end

  // Array storage is deliberately left without a reset
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Fetch port: a registered read that returns NOP while the contents are in flux or the address is out of range
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_rom <= NOP_WORD;
    end else if (state != ST_IDLE || address_rom[15:DEPTH_LOG2] != '0) begin
      q_rom <= NOP_WORD;
    end else begin
      q_rom <= mem[address_rom[DEPTH_LOG2-1:0]];
    end
  end

  // Control FSM: clear sweep, idle, byte-pair load, with registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
`ifdef PROG_ROM_CLEAR_EN
      state      <= ST_CLEAR;
      load_ready <= 1'b0;
      load_busy  <= 1'b1;
`else
      state      <= ST_IDLE;
      load_ready <= 1'b1;
      load_busy  <= 1'b0;
`endif
      wp         <= '0;
      phase_high <= 1'b0;
      low_byte   <= '0;
      load_count <= '0;
      load_error <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (wp[DEPTH_LOG2-1:0] == '1) begin
            state      <= ST_IDLE;
            wp         <= '0;
            load_ready <= 1'b1;
            load_busy  <= 1'b0;
          end else begin
            wp <= wp + WP_ONE;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            // The first byte of a load is always a low byte
            load_count <= '0;
            wp         <= '0;
            low_byte   <= load_data;
            if (load_last) begin
              load_error <= 1'b1;
            end else begin
              load_error <= 1'b0;
              state      <= ST_LOAD;
              load_busy  <= 1'b1;
              phase_high <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (!phase_high) begin
              low_byte <= load_data;
              if (load_last) begin
                load_error <= 1'b1;
                state      <= ST_IDLE;
                load_busy  <= 1'b0;
              end else begin
                phase_high <= 1'b1;
              end
            end else begin
              phase_high <= 1'b0;
              // Once the array is full, further words are dropped and the counters hold
              if (!wp_full) begin
                wp         <= wp + WP_ONE;
                load_count <= load_count + CNT_ONE;
              end else begin
                load_error <= 1'b1;
              end
              if (load_last) begin
                state     <= ST_IDLE;
                load_busy <= 1'b0;
              end
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          load_ready <= 1'b1;
          load_busy  <= 1'b0;
          phase_high <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_rom_server.sv
// Randomized scoreboard bench for prog_rom_server with DEPTH_LOG2=4.
// The driver predicts the outputs after each edge and queues them; the monitor compares those after each edge.
module tb_prog_rom_server;

  localparam int DEPTH = 16;
  localparam logic [15:0] NOP = 16'h0018;
`ifdef PROG_ROM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address_rom = '0;
  logic [15:0] q_rom;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [7:0]  load_data = '0;
  logic        load_last = 1'b0;
  logic        load_busy;
  logic [15:0] load_count;
  logic        load_error;

  prog_rom_server #(.DEPTH_LOG2(4), .NOP_WORD(16'h0018)) dut (
    .clock(clock), .reset_n(reset_n), .address_rom(address_rom), .q_rom(q_rom),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .load_busy(load_busy), .load_count(load_count),
    .load_error(load_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] q;
    bit          q_chk;
    bit          rdy;
    bit          busy;
    logic [15:0] cnt;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: the memory image plus the loader's word/byte progress
  int          clear_left;
  bit          in_load;
  bit          have_half;
  logic [7:0]  half;
  int          wp_m;
  logic [15:0] cnt_m;
  bit          err_m;
  logic [15:0] mem_m [DEPTH];
  bit          known [DEPTH];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    clear_left = CLR_EN ? DEPTH : 0;
    in_load = 0; have_half = 0; half = '0;
    wp_m = 0; cnt_m = '0; err_m = 0;
    if (!CLR_EN) for (int i = 0; i < DEPTH; i++) known[i] = 0;
  endtask

  // Present one cycle of stimulus and queue the prediction for the following edge
  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input logic [15:0] a);
    exp_t e;
    bit acc;
    @(negedge clock);
    load_valid = v; load_data = d; load_last = l; address_rom = a;
    e.q_chk = 1;
    e.q = NOP;
    if (clear_left > 0 || in_load || a >= DEPTH) e.q = NOP;
    else if (known[a[3:0]]) e.q = mem_m[a[3:0]];
    else e.q_chk = 0;
    acc = v && (clear_left == 0);
    if (clear_left > 0) begin
      mem_m[DEPTH - clear_left] = NOP;
      known[DEPTH - clear_left] = 1;
      clear_left--;
    end else if (acc) begin
      if (!in_load) begin
        in_load = 1; cnt_m = '0; err_m = 0; wp_m = 0; have_half = 0;
      end
      if (!have_half) begin
        if (l) begin err_m = 1; in_load = 0; end
        else begin half = d; have_half = 1; end
      end else begin
        have_half = 0;
        if (wp_m < DEPTH) begin
          mem_m[wp_m] = {d, half};
          known[wp_m] = 1;
          wp_m++;
          cnt_m++;
        end else begin
          err_m = 1;
        end
        if (l) in_load = 0;
      end
    end
    e.rdy  = (clear_left == 0);
    e.busy = (clear_left > 0) || in_load;
    e.cnt  = cnt_m;
    e.err  = err_m;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 65535));
    return 16'($urandom_range(0, 19));
  endfunction

  // Assert reset asynchronously, check the reset values at once, and release it mid-cycle
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_q", q_rom, NOP);
    chk("rst_ready", {15'd0, load_ready}, {15'd0, !CLR_EN});
    chk("rst_busy", {15'd0, load_busy}, {15'd0, CLR_EN});
    chk("rst_count", load_count, 16'd0);
    chk("rst_error", {15'd0, load_error}, 16'd0);
    load_valid = 1'b0; load_last = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  // Monitor: compare the DUT against the oldest prediction after every active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && sb.size() > 0) begin
        e = sb.pop_front();
        if (e.q_chk) chk("q_rom", q_rom, e.q);
        chk("load_ready", {15'd0, load_ready}, {15'd0, e.rdy});
        chk("load_busy", {15'd0, load_busy}, {15'd0, e.busy});
        chk("load_count", load_count, e.cnt);
        chk("load_error", {15'd0, load_error}, {15'd0, e.err});
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin known[i] = 0; mem_m[i] = '0; end
    do_reset();

    // Clear sweep: loader bytes offered during CLEAR must be ignored
    for (int i = 0; i < 2 * DEPTH; i++)
      cycle((clear_left > 0) ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom), 1'b0, 16'(i % DEPTH));

    // Directed load 06,00,00,00
    cycle(1, 8'h06, 0, 16'd0);
    cycle(1, 8'h00, 0, 16'd0);
    cycle(1, 8'h00, 0, 16'd1);
    cycle(1, 8'h00, 1, 16'd1);
    @(posedge clock); #2;
    chk("dir_count", load_count, 16'd2);
    cycle(0, 8'h00, 0, 16'd0);
    cycle(0, 8'h00, 0, 16'd1);
    cycle(0, 8'h00, 0, 16'h0010);
    @(posedge clock); #2;
    chk("dir_out_of_range", q_rom, NOP);

    // load_last on the 3rd byte: one word written, word 1 untouched
    cycle(1, 8'h34, 0, 16'd0);
    cycle(1, 8'h12, 0, 16'd1);
    cycle(1, 8'h77, 1, 16'd2);
    @(posedge clock); #2;
    chk("part_error", {15'd0, load_error}, 16'd1);
    chk("part_count", load_count, 16'd1);
    cycle(0, 8'h00, 0, 16'd1);
    cycle(0, 8'h00, 0, 16'd0);

    // Overflow: 17 words into a 16-word array
    for (int w = 0; w < DEPTH + 1; w++) begin
      cycle(1, 8'($urandom), 0, rand_addr());
      cycle(1, 8'($urandom), (w == DEPTH), rand_addr());
    end
    @(posedge clock); #2;
    chk("ovf_error", {15'd0, load_error}, 16'd1);
    chk("ovf_count", load_count, 16'd16);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 0, 16'(i));

    // Random loads of random length with idle gaps and random fetch addresses
    for (int t = 0; t < 40; t++) begin
      int nb;
      nb = $urandom_range(1, 12);
      for (int b = 0; b < nb; b++) begin
        while ($urandom_range(0, 3) == 0) cycle(0, 8'($urandom), 1'($urandom_range(0, 1)), rand_addr());
        cycle(1, 8'($urandom), (b == nb - 1), rand_addr());
      end
      for (int g = $urandom_range(0, 4); g > 0; g--) cycle(0, 8'h00, 0, rand_addr());
    end

    // Reset in the middle of a load, while byte 3 is on the bus
    cycle(1, 8'hAA, 0, 16'd0);
    cycle(1, 8'hBB, 0, 16'd1);
    @(negedge clock);
    load_valid = 1'b1; load_data = 8'hCC;
    do_reset();
    for (int i = 0; i < 2 * DEPTH + 2; i++) cycle(0, 8'h00, 0, 16'(i % DEPTH));
    cycle(1, 8'h11, 0, 16'd0);
    cycle(1, 8'h22, 1, 16'd0);
    cycle(0, 8'h00, 0, 16'd0);

    repeat (3) @(posedge clock);
    #3;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_rom_server.md
# prog_rom_server

Program-memory responder for the ALU core's instruction fetch port: it answers `address_rom` with `q_rom` one cycle later, which the core's FETCH wait state absorbs. It also accepts a byte-stream program load over a valid/ready handshake and assembles the bytes into 16-bit words. Reads return the NOP opcode while the memory is being cleared or loaded, so the core idles safely. It sits between the ALU core and the board-level loader (UART/JTAG bridge).

## Interface
- `DEPTH_LOG2`, 8 — memory holds 2^DEPTH_LOG2 16-bit words.
- `NOP_WORD`, 16'h0018 — word returned for masked or out-of-range reads; also the clear fill value.
- `clock`  in  1  — single clock; all logic on its rising edge.
- `reset_n`  in  1  — reset, asynchronous, active-low.
- `address_rom`  in  16  — fetch address from the core.
- `q_rom`  out  16  — registered fetch data.
- `load_valid`  in  1  — loader byte valid.
- `load_ready`  out  1  — block accepts a byte this cycle.
- `load_data`  in  8  — loader byte; low byte of each word first.
- `load_last`  in  1  — qualifies the final byte of a load.
- `load_busy`  out  1  — high in CLEAR or LOAD.
- `load_count`  out  16  — words written by the current or most recent load.
- `load_error`  out  1  — sticky load fault flag.

## Operation
- Storage is 2^DEPTH_LOG2 × 16. The array itself is not reset.
- State machine has three states: CLEAR, IDLE, LOAD.
- **Reset** (async, enters CLEAR):
  - `q_rom` = NOP_WORD, `load_ready` = 0, `load_busy` = 1, `load_count` = 0, `load_error` = 0.
  - Write pointer `wp` = 0, byte phase = low.
- **CLEAR**:
  - Writes NOP_WORD to address `wp`, then increments `wp`.
  - After writing the last address, goes to IDLE and sets `wp` = 0.
- **IDLE**:
  - `load_ready` = 1, `load_busy` = 0.
  - A handshake (`load_valid & load_ready`) moves to LOAD and processes that byte as the first byte of the load.
  - Starting a load clears `load_count`, `load_error` and `wp`.
- **LOAD**:
  - `load_ready` = 1.
  - A low byte is held in a latch.
  - A high byte writes {high, low} to `wp`, then increments `wp` and `load_count`.
  - `load_last` on a high byte: the word is written and the state returns to IDLE.
  - `load_last` on a low byte: the partial word is discarded, `load_error` is set, and the state returns to IDLE.
  - Word completion with `wp` = 2^DEPTH_LOG2: the word is dropped, `load_error` is set, and `wp`/`load_count` saturate. Bytes are still accepted until `load_last`.
- **Read path**:
  - `q_rom` is registered every cycle.
  - Returns NOP_WORD if the state is CLEAR or LOAD, or if `address_rom[15:DEPTH_LOG2]` ≠ 0.
  - Otherwise returns mem[`address_rom[DEPTH_LOG2-1:0]`].
- `reset_n` low mid-load or mid-clear aborts at once. Partially written contents stay in the array but are overwritten by CLEAR (when the macro below is enabled).

## Timing
- Read latency: exactly 1 cycle. An address sampled at edge N appears on `q_rom` after edge N; a new address is accepted every cycle.
- CLEAR lasts 2^DEPTH_LOG2 cycles. `load_ready` rises in the cycle after the last clear write.
- Loader throughput: 1 byte per cycle, so one word per 2 accepted bytes. `load_ready` never deasserts in IDLE or LOAD.
- The state is IDLE in the cycle after the final handshake. An address sampled at that edge already returns the loaded data.
- Simultaneous read and write to the same address cannot occur, because reads are masked in LOAD.

## Configuration
- `PROG_ROM_CLEAR_EN`
  - Defined: reset enters CLEAR and behaves as above.
  - Undefined: reset enters IDLE directly. `load_ready` = 1 and `load_busy` = 0 from the first cycle after reset release. Array contents are undefined until loaded; reads of never-written words are unspecified.

## Test plan
- Reset release with DEPTH_LOG2=4 and CLEAR enabled:
  - `load_ready` stays 0 for 16 cycles, then goes to 1.
  - Reading addresses 0–15 returns 16'h0018 each, 1 cycle after each address.
- Load bytes 06,00,00,00 (`load_last` on the 4th byte):
  - `load_count` = 2.
  - Reading address 0 gives 16'h0006 and address 1 gives 16'h0000, the cycle after the last handshake.
- Out-of-range read: `address_rom` = 16'h0010 with DEPTH_LOG2=4 returns 16'h0018.
- Reads during LOAD return 16'h0018 regardless of contents.
- `load_last` on the 3rd byte of a load:
  - `load_error` = 1, `load_count` = 1.
  - Word 1 is unchanged.
- Overflow: 17 words into DEPTH_LOG2=4 gives `load_error` = 1 and `load_count` = 16.
- Reset mid-load: `reset_n` low during byte 3.
  - Outputs take their reset values immediately (`q_rom` = 16'h0018, `load_busy` = 1).
  - CLEAR then reruns.
